vga_scan_engine: RTL and testbench

Parametrised successor to the VGA timing/display pair. It generates the VGA raster and derives framebuffer read addresses with integer upscaling and centring from that raster. It expands stored pixels to RGB in mono or packed-colour mode and outputs latency-aligned sync, blank and colour. It sits between the dual-port framebuffer read port (1-cycle synchronous read) and the VGA DAC pins, and runs entirely in the 25 MHz pixel domain.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing.sv | 59 +++++
 rtl/vga_scan_engine.sv | 149 ++++++++++++++
 tb/tb_vga_scan_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, control-word layout and pixel-to-RGB expansion.
package vga_pkg;
   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int MAX_RGB_W  = 24;

   function automatic int total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_D = total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int V_TOTAL_D = total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

   // Counter width helper that never collapses to zero bits.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {PIX_MONO, PIX_PACKED} pix_mode_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic win;
      logic fs;
   } ctl_t;

   function automatic logic [MAX_RGB_W-1:0] expand_pix(input pix_mode_e mode,
                                                       input logic [MAX_RGB_W-1:0] data,
                                                       input int rgb_w);
      logic [MAX_RGB_W-1:0] ones;
      ones = ~({MAX_RGB_W{1'b1}} << rgb_w);
      if (mode == PIX_MONO) return data[0] ? ones : '0;
      return data & ones;
   endfunction
endpackage

// File: rtl/vga_timing.sv
// Raster counters plus stage-0 sync, active-video and image-window flags.
module vga_timing import vga_pkg::*; #(
   parameter int   H_ACTIVE = H_ACTIVE_D,
   parameter int   H_FP     = H_FP_D,
   parameter int   H_SYNC   = H_SYNC_D,
   parameter int   H_BP     = H_BP_D,
   parameter int   V_ACTIVE = V_ACTIVE_D,
   parameter int   V_FP     = V_FP_D,
   parameter int   V_SYNC   = V_SYNC_D,
   parameter int   V_BP     = V_BP_D,
   parameter logic SYNC_POL = 1'b0,
   parameter int   H_OFF    = 0,
   parameter int   V_OFF    = 0,
   parameter int   WIN_W    = H_ACTIVE,
   parameter int   WIN_H    = V_ACTIVE
) (
   input  logic clk_25,
   input  logic reset_n,
   output logic hs0,
   output logic vs0,
   output logic de0,
   output logic win0,
   output logic fs0,
   output logic frame_end
);
   localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = cw(H_TOTAL);
   localparam int VW      = cw(V_TOTAL);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_last, v_last;

   assign h_last = (h == HW'(H_TOTAL - 1));
   assign v_last = (v == VW'(V_TOTAL - 1));

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         h <= '0;
         v <= '0;
      end else if (h_last) begin
         h <= '0;
         v <= v_last ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   // Offset-subtract-and-compare: a position left of the window wraps to a
   // large unsigned value, so one comparator covers both edges.
   assign win0 = ((h - HW'(H_OFF)) < HW'(WIN_W)) && ((v - VW'(V_OFF)) < VW'(WIN_H));

   assign hs0 = ((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
   assign vs0 = ((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
   assign de0 = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
   assign fs0 = (h == '0) && (v == '0);
   assign frame_end = h_last && v_last;
endmodule

// File: rtl/vga_scan_engine.sv
// VGA raster with integer-upscaled, centred framebuffer fetch and latency-aligned outputs.
module vga_scan_engine import vga_pkg::*; #(
   parameter int   H_ACTIVE   = H_ACTIVE_D,
   parameter int   H_FP       = H_FP_D,
   parameter int   H_SYNC     = H_SYNC_D,
   parameter int   H_BP       = H_BP_D,
   parameter int   V_ACTIVE   = V_ACTIVE_D,
   parameter int   V_FP       = V_FP_D,
   parameter int   V_SYNC     = V_SYNC_D,
   parameter int   V_BP       = V_BP_D,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   IMG_W      = 160,
   parameter int   IMG_H      = 120,
   parameter int   SCALE      = 4,
   parameter int   ADDR_WIDTH = 15,
   parameter int   PIX_W      = 1,
   parameter int   COLOR_W    = 1,
   parameter logic [3*COLOR_W-1:0] BORDER = '0
) (
   input  logic                  clk_25,
   input  logic                  reset_n,
   input  logic                  video_en,
   input  logic [PIX_W-1:0]      fb_data,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [3*COLOR_W-1:0]  rgb,
   output logic                  hs,
   output logic                  vs,
   output logic                  de,
   output logic                  frame_start
);
   localparam int RGB_W  = 3 * COLOR_W;
   localparam int WIN_W  = IMG_W * SCALE;
   localparam int WIN_H  = IMG_H * SCALE;
   localparam int H_OFF  = (H_ACTIVE - WIN_W) / 2;
   localparam int V_OFF  = (V_ACTIVE - WIN_H) / 2;
   localparam int STAGES = 2;
   localparam int SW     = cw(SCALE);
   localparam int CW     = cw(IMG_W);
   localparam pix_mode_e MODE = (PIX_W == 1) ? PIX_MONO : PIX_PACKED;
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'((IMG_H - 1) * IMG_W);
   localparam ctl_t CTL_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, win: 1'b0, fs: 1'b0};

   if (SCALE < 1 || SCALE > 8) begin : g_bad_scale
      $error("SCALE must be within 1..8");
   end
   if (WIN_W > H_ACTIVE || WIN_H > V_ACTIVE) begin : g_bad_window
      $error("scaled image does not fit the active area");
   end
   if (PIX_W != 1 && PIX_W != RGB_W) begin : g_bad_pix
      $error("PIX_W must be 1 or 3*COLOR_W");
   end
   if (RGB_W > MAX_RGB_W) begin : g_bad_color
      $error("COLOR_W too wide");
   end
   if ((64'd1 << ADDR_WIDTH) < 64'(IMG_W * IMG_H)) begin : g_bad_addr
      $error("ADDR_WIDTH too small for the image");
   end

   logic hs0, vs0, de0, win0, fs0, frame_end;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL), .H_OFF(H_OFF), .V_OFF(V_OFF), .WIN_W(WIN_W), .WIN_H(WIN_H)
   ) u_timing (
      .clk_25(clk_25), .reset_n(reset_n),
      .hs0(hs0), .vs0(vs0), .de0(de0), .win0(win0), .fs0(fs0), .frame_end(frame_end)
   );

   // Incremental address walk: state always names the next in-window pixel.
   logic [SW-1:0]         hsub, vsub;
   logic [CW-1:0]         col;
   logic [ADDR_WIDTH-1:0] row_base, addr_hold;

   assign fb_addr = win0 ? (row_base + ADDR_WIDTH'(col)) : addr_hold;

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         hsub      <= '0;
         vsub      <= '0;
         col       <= '0;
         row_base  <= '0;
         addr_hold <= '0;
      end else begin
         addr_hold <= fb_addr;
         if (frame_end) begin
            hsub     <= '0;
            vsub     <= '0;
            col      <= '0;
            row_base <= '0;
         end else if (win0) begin
            if (hsub == SW'(SCALE - 1)) begin
               hsub <= '0;
               if (col == CW'(IMG_W - 1)) begin
                  col <= '0;
                  if (vsub == SW'(SCALE - 1)) begin
                     vsub     <= '0;
                     row_base <= (row_base == LAST_ROW) ? '0 : row_base + ROW_STEP;
                  end else begin
                     vsub <= vsub + 1'b1;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end else begin
               hsub <= hsub + 1'b1;
            end
         end
      end
   end

   // The frame-start pixel itself already honours the freshly sampled enable.
   logic en_frame, img_en;

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n)  en_frame <= 1'b0;
      else if (fs0)  en_frame <= video_en;
   end

   assign img_en = fs0 ? video_en : en_frame;

   ctl_t                  ctl0;
   ctl_t [STAGES:1]       ctl_pipe;
   logic [STAGES:1]       vld_pipe;
   logic [RGB_W-1:0]      pix_rgb;

   assign ctl0    = '{hs: hs0, vs: vs0, win: win0 & img_en, fs: fs0};
   assign pix_rgb = RGB_W'(expand_pix(MODE, MAX_RGB_W'(fb_data), RGB_W));

   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         ctl_pipe <= {STAGES{CTL_RST}};
         rgb      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], de0};
         ctl_pipe <= {ctl_pipe[STAGES-1:1], ctl0};
         if (!vld_pipe[1])         rgb <= '0;
         else if (ctl_pipe[1].win) rgb <= pix_rgb;
         else                      rgb <= BORDER;
      end
   end

   assign hs          = ctl_pipe[STAGES].hs;
   assign vs          = ctl_pipe[STAGES].vs;
   assign frame_start = ctl_pipe[STAGES].fs;
   assign de          = vld_pipe[STAGES];
endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboarded bench: a packed-colour and a mono engine on a shrunken raster.
module tb_vga_scan_engine;
   localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
   localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int IW [2] = '{10, 7};
   localparam int IH [2] = '{8, 5};
   localparam int SC [2] = '{3, 4};
   localparam int HO [2] = '{5, 6};
   localparam int VO [2] = '{3, 5};
   localparam logic [2:0] BD [2] = '{3'b010, 3'b100};

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
      logic [2:0] rgb;
   } exp_t;
   localparam exp_t RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 3'b000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n = 1'b0;
   logic       video_en = 1'b0;
   logic [2:0] fb_data_p;
   logic       fb_data_m;
   logic [6:0] fb_addr_p;
   logic [5:0] fb_addr_m;
   logic [2:0] rgb_p, rgb_m;
   logic       hs_p, vs_p, de_p, fs_p, hs_m, vs_m, de_m, fs_m;

   vga_scan_engine #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
      .IMG_W(10), .IMG_H(8), .SCALE(3), .ADDR_WIDTH(7), .PIX_W(3), .COLOR_W(1), .BORDER(3'b010)
   ) u_pack (
      .clk_25(clk), .reset_n(reset_n), .video_en(video_en), .fb_data(fb_data_p),
      .fb_addr(fb_addr_p), .rgb(rgb_p), .hs(hs_p), .vs(vs_p), .de(de_p), .frame_start(fs_p)
   );

   vga_scan_engine #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
      .IMG_W(7), .IMG_H(5), .SCALE(4), .ADDR_WIDTH(6), .PIX_W(1), .COLOR_W(1), .BORDER(3'b100)
   ) u_mono (
      .clk_25(clk), .reset_n(reset_n), .video_en(video_en), .fb_data(fb_data_m),
      .fb_addr(fb_addr_m), .rgb(rgb_m), .hs(hs_m), .vs(vs_m), .de(de_m), .frame_start(fs_m)
   );

   function automatic logic [2:0] pix(input int i, input int a);
      if (i == 0) return 3'((a * 3 + 1) % 8);
      return (((a ^ (a >> 2)) & 1) != 0) ? 3'b111 : 3'b000;
   endfunction

   // Synchronous-read framebuffer models.
   always @(posedge clk) begin
      fb_data_p <= pix(0, int'(fb_addr_p));
      fb_data_m <= fb_addr_m[0] ^ fb_addr_m[2];
   end

   int   checks = 0, errors = 0;
   exp_t q_p[$], q_m[$];
   int   mh, mv, hold[2], max_addr[2];
   logic m_en = 1'b0;
   bit   mon_on = 1'b0;

   task automatic model_step();
      exp_t e;
      bit   inw;
      int   got;
      if (mh == 0 && mv == 0) m_en = video_en;
      for (int i = 0; i < 2; i++) begin
         inw = mh >= HO[i] && mh < HO[i] + IW[i] * SC[i] && mv >= VO[i] && mv < VO[i] + IH[i] * SC[i];
         if (inw) hold[i] = ((mv - VO[i]) / SC[i]) * IW[i] + (mh - HO[i]) / SC[i];
         got = (i == 0) ? int'(fb_addr_p) : int'(fb_addr_m);
         if (got > max_addr[i]) max_addr[i] = got;
         checks++;
         if (got != hold[i]) begin
            errors++;
            $display("FAIL fb_addr[%0d] x=%0d y=%0d: got %0d expected %0d", i, mh, mv, got, hold[i]);
         end
         e.hs  = !(mh >= HA + HFP && mh < HA + HFP + HS);
         e.vs  = !(mv >= VA + VFP && mv < VA + VFP + VS);
         e.de  = mh < HA && mv < VA;
         e.fs  = mh == 0 && mv == 0;
         e.rgb = !e.de ? 3'b000 : (inw && m_en) ? pix(i, hold[i]) : BD[i];
         if (i == 0) q_p.push_back(e);
         else        q_m.push_back(e);
      end
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
         mh++;
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         exp_t e, g;
         for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
               e = q_p.pop_front();
               g = '{hs: hs_p, vs: vs_p, de: de_p, fs: fs_p, rgb: rgb_p};
            end else begin
               e = q_m.pop_front();
               g = '{hs: hs_m, vs: vs_m, de: de_m, fs: fs_m, rgb: rgb_m};
            end
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL outputs[%0d] {hs,vs,de,fs,rgb} at t=%0t: got %b expected %b", i, $time, g, e);
            end
         end
         model_step();
      end
   end

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      q_p.delete();
      q_m.delete();
      q_p.push_back(RST);
      q_m.push_back(RST);
      mh = 0;
      mv = 0;
      hold = '{0, 0};
      model_step();
      mon_on = 1'b1;
   endtask

   task automatic test_reset();
      exp_t g;
      reset_n  = 1'b0;
      video_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      g = '{hs: hs_p, vs: vs_p, de: de_p, fs: fs_p, rgb: rgb_p};
      checks++;
      if (g !== RST) begin errors++; $display("FAIL reset_outputs_p: got %b expected %b", g, RST); end
      g = '{hs: hs_m, vs: vs_m, de: de_m, fs: fs_m, rgb: rgb_m};
      checks++;
      if (g !== RST) begin errors++; $display("FAIL reset_outputs_m: got %b expected %b", g, RST); end
      checks++;
      if (fb_addr_p !== 7'd0 || fb_addr_m !== 6'd0) begin
         errors++;
         $display("FAIL reset_fb_addr: got %0d/%0d expected 0/0", fb_addr_p, fb_addr_m);
      end
      release_reset();
   endtask

   task automatic wait_fs(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (fs_p !== 1'b1 && n < 2 * FRAME);
      checks++;
      if (fs_p !== 1'b1) begin errors++; $display("FAIL %s: no frame_start within %0d cycles", tag, n); end
   endtask

   task automatic test_sync_frame();
      int hs_low = 0, vs_low = 0, fs_cnt = 0, hs_low_m = 0;
      wait_fs("sync_wait_fs");
      max_addr = '{0, 0};
      for (int k = 0; k < FRAME; k++) begin
         if (hs_p === 1'b0) hs_low++;
         if (hs_m === 1'b0) hs_low_m++;
         if (vs_p === 1'b0) vs_low++;
         if (fs_p === 1'b1) fs_cnt++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (hs_low != VT * HS) begin errors++; $display("FAIL hs_low_cycles: got %0d expected %0d", hs_low, VT * HS); end
      checks++;
      if (hs_low_m != VT * HS) begin errors++; $display("FAIL hs_low_cycles_m: got %0d expected %0d", hs_low_m, VT * HS); end
      checks++;
      if (vs_low != VS * HT) begin errors++; $display("FAIL vs_low_cycles: got %0d expected %0d", vs_low, VS * HT); end
      checks++;
      if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt); end
      checks++;
      if (fs_p !== 1'b1) begin errors++; $display("FAIL frame_start_period: got %b expected 1 after %0d cycles", fs_p, FRAME); end
      checks++;
      if (max_addr[0] != IW[0] * IH[0] - 1) begin
         errors++;
         $display("FAIL last_addr_p: got %0d expected %0d", max_addr[0], IW[0] * IH[0] - 1);
      end
      checks++;
      if (max_addr[1] != IW[1] * IH[1] - 1) begin
         errors++;
         $display("FAIL last_addr_m: got %0d expected %0d", max_addr[1], IW[1] * IH[1] - 1);
      end
   endtask

   task automatic test_video_en();
      int n = 0, img_p = 0, img_m = 0, exp_p = 0, exp_m = 0;
      for (int a = 0; a < IW[0] * IH[0]; a++) if (pix(0, a) != BD[0]) exp_p += SC[0] * SC[0];
      for (int a = 0; a < IW[1] * IH[1]; a++) if (pix(1, a) != BD[1]) exp_m += SC[1] * SC[1];
      while (!(mv == 20 && mh == 10) && n < 2 * FRAME) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 2 * FRAME) begin errors++; $display("FAIL video_en_wait_line: timed out after %0d cycles", n); end
      video_en = 1'b0;
      wait_fs("disabled_frame_fs");
      for (int k = 0; k < FRAME; k++) begin
         if (k == FRAME / 2) video_en = 1'b1;
         if (de_p === 1'b1 && rgb_p !== BD[0]) img_p++;
         if (de_m === 1'b1 && rgb_m !== BD[1]) img_m++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (img_p != 0 || img_m != 0) begin
         errors++;
         $display("FAIL disabled_frame_image_pixels: got %0d/%0d expected 0/0", img_p, img_m);
      end
      img_p = 0;
      img_m = 0;
      for (int k = 0; k < FRAME; k++) begin
         if (de_p === 1'b1 && rgb_p !== BD[0]) img_p++;
         if (de_m === 1'b1 && rgb_m !== BD[1]) img_m++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (img_p != exp_p || img_m != exp_m) begin
         errors++;
         $display("FAIL reenabled_frame_image_pixels: got %0d/%0d expected %0d/%0d", img_p, img_m, exp_p, exp_m);
      end
   endtask

   task automatic test_reset_mid();
      int   n = 0;
      exp_t g;
      while (!(mv == 20 && mh == 30) && n < 2 * FRAME) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 2 * FRAME) begin errors++; $display("FAIL reset_mid_wait: timed out after %0d cycles", n); end
      mon_on  = 1'b0;
      reset_n = 1'b0;
      #1;
      g = '{hs: hs_p, vs: vs_p, de: de_p, fs: fs_p, rgb: rgb_p};
      checks++;
      if (g !== RST) begin errors++; $display("FAIL mid_reset_outputs_p: got %b expected %b", g, RST); end
      g = '{hs: hs_m, vs: vs_m, de: de_m, fs: fs_m, rgb: rgb_m};
      checks++;
      if (g !== RST) begin errors++; $display("FAIL mid_reset_outputs_m: got %b expected %b", g, RST); end
      checks++;
      if (fb_addr_p !== 7'd0 || fb_addr_m !== 6'd0) begin
         errors++;
         $display("FAIL mid_reset_fb_addr: got %0d/%0d expected 0/0", fb_addr_p, fb_addr_m);
      end
      repeat (4) @(negedge clk);
      release_reset();
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (fs_p !== 1'b1 && n < 10);
      checks++;
      if (n != 2) begin errors++; $display("FAIL first_frame_start_latency: got %0d expected 2", n); end
      repeat (FRAME + 100) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_sync_frame();
      test_video_en();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
